port_group_scheduler: RTL

Issue-side scheduler for the vector core's write-port groups and their paired read ports. It sits in the vector control unit between the instruction decoder and the VRF port datapath. It accepts one instruction per handshake and grants it a free port group in round-robin order, plus a second group's read port when a third operand is needed. It blocks RAW/WAW hazards against in-flight destinations and frees groups when their element count drains.

---
 rtl/port_sched_pkg.sv | 31 +++
 rtl/port_group_tracker.sv | 85 ++++++++
 rtl/port_group_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/port_sched_pkg.sv
// Shared types and helpers for the vector write-port group scheduler.
package port_sched_pkg;

  localparam int unsigned VREG_W = 5;
  // Widest group vector the rotating search supports.
  localparam int unsigned MAX_GROUPS = 32;

  typedef enum logic [1:0] {
    StFree,
    StRun,
    StLinked
  } grp_state_e;

  // First set bit of req[n-1:0], scanning upward from start with wrap.
  function automatic int unsigned rr_first_set(input logic [MAX_GROUPS-1:0] req,
                                               input int unsigned start,
                                               input int unsigned n,
                                               output logic found);
    int unsigned idx;
    rr_first_set = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_GROUPS; i++) begin
      idx = (start + i) % n;
      if (i < n && !found && req[idx[4:0]]) begin
        found = 1'b1;
        rr_first_set = idx;
      end
    end
  endfunction

endpackage

// File: rtl/port_group_tracker.sv
// Per-group state: FREE / RUN (owner with element counter) / LINKED (op3 read reservation).
module port_group_tracker
  import port_sched_pkg::*;
#(
  parameter int unsigned VL_W    = 12,
  parameter int unsigned OWNER_W = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               alloc_run_i,
  input  logic               alloc_link_i,
  input  logic [VL_W-1:0]    vl_i,
  input  logic [VREG_W-1:0]  vd_i,
  input  logic [OWNER_W-1:0] owner_i,
  input  logic               done_i,
  input  logic               owner_rel_i,
  output grp_state_e         state_o,
  output logic [VREG_W-1:0]  vd_o,
  output logic [OWNER_W-1:0] owner_o,
  output logic               busy_o,
  output logic               run_rel_o,
  output logic               release_o,
  output logic               err_o
);

  grp_state_e         state_q, state_d;
  logic [VL_W-1:0]    cnt_q, cnt_d;
  logic [VREG_W-1:0]  vd_q, vd_d;
  logic [OWNER_W-1:0] owner_q, owner_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vd_d    = vd_q;
    owner_d = owner_q;
    // A zero count only exists for vl = 0, which releases without a strobe.
    run_rel_o = (state_q == StRun) && ((cnt_q == '0) || (done_i && cnt_q == VL_W'(1)));
    release_o = run_rel_o || ((state_q == StLinked) && owner_rel_i);
    err_o     = done_i && ((state_q != StRun) || (cnt_q == '0));
    unique case (state_q)
      StFree: begin
        if (alloc_run_i) begin
          state_d = StRun;
          cnt_d   = vl_i;
          vd_d    = vd_i;
        end else if (alloc_link_i) begin
          state_d = StLinked;
          owner_d = owner_i;
        end
      end
      StRun: begin
        if (run_rel_o) begin
          state_d = StFree;
          cnt_d   = '0;
        end else if (done_i) begin
          cnt_d = cnt_q - VL_W'(1);
        end
      end
      StLinked: begin
        if (owner_rel_i) state_d = StFree;
      end
      default: state_d = StFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StFree;
      cnt_q   <= '0;
      vd_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vd_q    <= vd_d;
      owner_q <= owner_d;
    end
  end

  assign state_o = state_q;
  assign vd_o    = vd_q;
  assign owner_o = owner_q;
  assign busy_o  = (state_q != StFree);

endmodule

// File: rtl/port_group_scheduler.sv
// Round-robin issue scheduler for VRF write-port groups with op3 read-port linking
// and RAW/WAW hazard blocking against in-flight destinations.
module port_group_scheduler
  import port_sched_pkg::*;
#(
  parameter int unsigned W_PORTS_NUM = 4,
  parameter int unsigned R_PORTS_NUM = 2 * W_PORTS_NUM,
  parameter int unsigned VL_W        = 12
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           issue_vld_i,
  output logic                           issue_rdy_o,
  input  logic [VL_W-1:0]                issue_vl_i,
  input  logic [VREG_W-1:0]              issue_vd_i,
  input  logic [VREG_W-1:0]              issue_vs1_i,
  input  logic [VREG_W-1:0]              issue_vs2_i,
  input  logic                           issue_use_vs1_i,
  input  logic                           issue_use_vs2_i,
  input  logic                           issue_op3_i,
  output logic                           grant_vld_o,
  output logic [$clog2(W_PORTS_NUM)-1:0] grant_port_o,
  output logic [$clog2(R_PORTS_NUM)-1:0] grant_op3_port_o,
  input  logic [W_PORTS_NUM-1:0]         elem_done_i,
  output logic [W_PORTS_NUM-1:0]         port_busy_o,
  output logic [W_PORTS_NUM-1:0]         port_release_o,
  output logic                           err_o
);

  localparam int unsigned PtrW = $clog2(W_PORTS_NUM);

  grp_state_e              grp_state [W_PORTS_NUM];
  logic [VREG_W-1:0]       grp_vd    [W_PORTS_NUM];
  logic [PtrW-1:0]         grp_owner [W_PORTS_NUM];
  logic [W_PORTS_NUM-1:0]  run_rel, owner_rel, err_ev, alloc_run, alloc_link;
  logic [MAX_GROUPS-1:0]   free_ext, h_req;
  logic                    g_found, h_found, hazard, accept;
  logic [PtrW-1:0]         g_sel, h_sel;
  logic [PtrW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    err_q;

  // Group search runs on registered state only, so same-cycle releases are not reusable.
  always_comb begin
    free_ext = '0;
    for (int unsigned i = 0; i < W_PORTS_NUM; i++) free_ext[i] = (grp_state[i] == StFree);
    g_sel = PtrW'(rr_first_set(free_ext, 32'(rr_ptr_q), W_PORTS_NUM, g_found));
    h_req = free_ext;
    for (int unsigned i = 0; i < W_PORTS_NUM; i++) begin
      if (g_sel == PtrW'(i)) h_req[i] = 1'b0;
    end
    h_sel = PtrW'(rr_first_set(h_req, 32'(g_sel) + 32'd1, W_PORTS_NUM, h_found));
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < W_PORTS_NUM; i++) begin
      if (grp_state[i] == StRun &&
          ((grp_vd[i] == issue_vd_i) ||
           (issue_use_vs1_i && grp_vd[i] == issue_vs1_i) ||
           (issue_use_vs2_i && grp_vd[i] == issue_vs2_i))) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    issue_rdy_o      = (issue_op3_i ? h_found : g_found) && !hazard;
    accept           = issue_vld_i && issue_rdy_o;
    grant_vld_o      = accept;
    grant_port_o     = accept ? g_sel : '0;
    grant_op3_port_o = (accept && issue_op3_i) ? {h_sel, 1'b0} : '0;
    rr_ptr_d         = rr_ptr_q;
    if (accept) rr_ptr_d = (issue_op3_i ? h_sel : g_sel) + PtrW'(1);
    for (int unsigned i = 0; i < W_PORTS_NUM; i++) begin
      alloc_run[i]  = accept && (g_sel == PtrW'(i));
      alloc_link[i] = accept && issue_op3_i && (h_sel == PtrW'(i));
      owner_rel[i]  = run_rel[grp_owner[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (|err_ev) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  for (genvar gi = 0; gi < W_PORTS_NUM; gi++) begin : g_trk
    port_group_tracker #(
      .VL_W    (VL_W),
      .OWNER_W (PtrW)
    ) u_trk (
      .clk          (clk),
      .rstn         (rstn),
      .alloc_run_i  (alloc_run[gi]),
      .alloc_link_i (alloc_link[gi]),
      .vl_i         (issue_vl_i),
      .vd_i         (issue_vd_i),
      .owner_i      (g_sel),
      .done_i       (elem_done_i[gi]),
      .owner_rel_i  (owner_rel[gi]),
      .state_o      (grp_state[gi]),
      .vd_o         (grp_vd[gi]),
      .owner_o      (grp_owner[gi]),
      .busy_o       (port_busy_o[gi]),
      .run_rel_o    (run_rel[gi]),
      .release_o    (port_release_o[gi]),
      .err_o        (err_ev[gi])
    );
  end

endmodule
